// File: rtl/graphics_pkg.sv
// Shared types and widths for the ball render sequencer.
//   COORD_W / COLOR_W : coordinate and colour widths
//   seq_state_e       : frame sequencer states
//   beat_t            : one output beat {x, y, color, last}
//   issue_t           : one issue pipeline stage {valid, x, y, last}
package graphics_pkg;

  localparam int unsigned COORD_W = 16;
  localparam int unsigned COLOR_W = 24;

  typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} seq_state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COLOR_W-1:0] color;
    logic               last;
  } beat_t;

  localparam int unsigned BEAT_W = $bits(beat_t);

  typedef struct packed {
    logic               valid;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               last;
  } issue_t;

endpackage

// File: rtl/ball_render_seq_if.sv
// Signal bundle around the ball render sequencer.
//   Position input  : pos_valid/pos_ready, pos_x/y/z, frame_start
//   Ball side       : x/y/z_loc, pixel_x/y out, color in
//   Beat output     : out_valid/out_ready, out_x/y, out_color, out_last
//   Status          : busy, frame_done, overrun
// slave is the sequencer's view; master is the surrounding logic's view.
interface ball_render_seq_if;
  import graphics_pkg::*;

  logic               pos_valid;
  logic               pos_ready;
  logic [COORD_W-1:0] pos_x;
  logic [COORD_W-1:0] pos_y;
  logic [COORD_W-1:0] pos_z;
  logic               frame_start;
  logic [COORD_W-1:0] x_loc;
  logic [COORD_W-1:0] y_loc;
  logic [COORD_W-1:0] z_loc;
  logic [COORD_W-1:0] pixel_x;
  logic [COORD_W-1:0] pixel_y;
  logic [COLOR_W-1:0] color;
  logic               out_valid;
  logic               out_ready;
  logic [COORD_W-1:0] out_x;
  logic [COORD_W-1:0] out_y;
  logic [COLOR_W-1:0] out_color;
  logic               out_last;
  logic               busy;
  logic               frame_done;
  logic               overrun;

  modport slave (
    input  pos_valid, pos_x, pos_y, pos_z, frame_start, color, out_ready,
    output pos_ready, x_loc, y_loc, z_loc, pixel_x, pixel_y,
    output out_valid, out_x, out_y, out_color, out_last, busy, frame_done, overrun
  );

  modport master (
    output pos_valid, pos_x, pos_y, pos_z, frame_start, color, out_ready,
    input  pos_ready, x_loc, y_loc, z_loc, pixel_x, pixel_y,
    input  out_valid, out_x, out_y, out_color, out_last, busy, frame_done, overrun
  );

endinterface

// File: rtl/ball_seq_fifo.sv
// Synchronous FIFO for output beats.
//   clk_i, rst_i     : clock, synchronous active-high reset (flushes)
//   push_i, wdata_i  : write side; push while full is dropped (callers hold credit)
//   pop_i, rdata_o   : read side; rdata_o is the head entry
//   empty_o, count_o : occupancy
module ball_seq_fifo #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned WIDTH = 57,
  parameter int unsigned CntW  = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PtrMax = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  always_comb begin
    push_ok  = push_i && (count_q != CntW'(DEPTH));
    pop_ok   = pop_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + AW'(1);
    count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only meaningful while count_q != 0.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/ball_render_seq.sv
// Frame sequencer for the Ball pixel renderer.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : ball_render_seq_if.slave (position in, Ball drive/return, beat stream, status)
// Latches a ball position in IDLE, scans pixels in raster order, tracks each issued pixel
// through a BALL_LAT-deep pipeline to meet Ball's colour, and buffers beats in a FIFO.
module ball_render_seq
  import graphics_pkg::*;
#(
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 480,
  parameter int unsigned BALL_LAT   = 1,
  parameter int unsigned FIFO_DEPTH = 3
) (
  input logic              clk,
  input logic              rst,
  ball_render_seq_if.slave bus
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [COORD_W-1:0] XMax = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] YMax = COORD_W'(V_RES - 1);

  seq_state_e         state_q, state_d;
  logic [COORD_W-1:0] pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
  logic [COORD_W-1:0] x_loc_q, x_loc_d, y_loc_q, y_loc_d, z_loc_q, z_loc_d;
  logic               overrun_q, overrun_d;
  issue_t             pipe_q [BALL_LAT];
  issue_t             issue_d;

  logic [CntW-1:0]    fifo_count;
  logic               fifo_empty, fifo_push, fifo_pop;
  beat_t              fifo_wdata, fifo_rdata;
  int unsigned        inflight;
  logic               do_issue, x_end, y_end;

  always_comb begin
    inflight = 0;
    for (int i = 0; i < BALL_LAT; i++) inflight = inflight + 32'(pipe_q[i].valid);
  end

  always_comb begin
    x_end = (pixel_x_q == XMax);
    y_end = (pixel_y_q == YMax);
    // Credit: every in-flight pixel already owns a FIFO slot, so the FIFO cannot overflow.
    do_issue = (state_q == StScan) && ((32'(fifo_count) + inflight) < FIFO_DEPTH);

    issue_d.valid = do_issue;
    issue_d.x     = pixel_x_q;
    issue_d.y     = pixel_y_q;
    issue_d.last  = x_end && y_end;

    state_d   = state_q;
    pixel_x_d = pixel_x_q;
    pixel_y_d = pixel_y_q;
    x_loc_d   = x_loc_q;
    y_loc_d   = y_loc_q;
    z_loc_d   = z_loc_q;
    overrun_d = overrun_q | (bus.frame_start && (state_q != StIdle));

    unique case (state_q)
      StIdle: begin
        if (bus.pos_valid) begin
          x_loc_d = bus.pos_x;
          y_loc_d = bus.pos_y;
          z_loc_d = bus.pos_z;
        end
        if (bus.frame_start) begin
          state_d   = StScan;
          pixel_x_d = '0;
          pixel_y_d = '0;
        end
      end
      StScan: begin
        if (do_issue) begin
          if (x_end && y_end) begin
            state_d   = StDrain;
            pixel_x_d = '0;
            pixel_y_d = '0;
          end else if (x_end) begin
            pixel_x_d = '0;
            pixel_y_d = pixel_y_q + COORD_W'(1);
          end else begin
            pixel_x_d = pixel_x_q + COORD_W'(1);
          end
        end
      end
      StDrain: if ((inflight == 0) && fifo_empty) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pixel_x_q <= '0;
      pixel_y_q <= '0;
      x_loc_q   <= '0;
      y_loc_q   <= '0;
      z_loc_q   <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < BALL_LAT; i++) pipe_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pixel_x_q <= pixel_x_d;
      pixel_y_q <= pixel_y_d;
      x_loc_q   <= x_loc_d;
      y_loc_q   <= y_loc_d;
      z_loc_q   <= z_loc_d;
      overrun_q <= overrun_d;
      pipe_q[0] <= issue_d;
      for (int i = 1; i < BALL_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // The last pipeline stage lines up with the colour Ball returns for that pixel.
  always_comb begin
    fifo_push        = pipe_q[BALL_LAT-1].valid;
    fifo_wdata.x     = pipe_q[BALL_LAT-1].x;
    fifo_wdata.y     = pipe_q[BALL_LAT-1].y;
    fifo_wdata.color = bus.color;
    fifo_wdata.last  = pipe_q[BALL_LAT-1].last;
    fifo_pop         = !fifo_empty && bus.out_ready;
  end

  ball_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BEAT_W),
    .CntW  (CntW)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign bus.pos_ready  = (state_q == StIdle);
  assign bus.busy       = (state_q == StScan) || (state_q == StDrain);
  assign bus.frame_done = (state_q == StDone);
  assign bus.overrun    = overrun_q;
  assign bus.x_loc      = x_loc_q;
  assign bus.y_loc      = y_loc_q;
  assign bus.z_loc      = z_loc_q;
  assign bus.pixel_x    = pixel_x_q;
  assign bus.pixel_y    = pixel_y_q;
  // Stale FIFO storage is masked so the beat outputs read zero whenever nothing is offered.
  assign bus.out_valid  = !fifo_empty;
  assign bus.out_x      = fifo_empty ? '0 : fifo_rdata.x;
  assign bus.out_y      = fifo_empty ? '0 : fifo_rdata.y;
  assign bus.out_color  = fifo_empty ? '0 : fifo_rdata.color;
  assign bus.out_last   = fifo_empty ? 1'b0 : fifo_rdata.last;

endmodule

// File: tb/tb_ball_render_seq.sv
module tb_ball_render_seq;
  import graphics_pkg::*;

  localparam int unsigned H = 4;
  localparam int unsigned V = 3;
  localparam int unsigned LAT = 1;
  localparam int unsigned DEPTH = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ball_render_seq_if bus();

  ball_render_seq #(
    .H_RES      (H),
    .V_RES      (V),
    .BALL_LAT   (LAT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Behavioural Ball: colour is a function of ball position and pixel, one cycle later.
  function automatic logic [23:0] ball_fn(input logic [15:0] lx, input logic [15:0] ly,
                                          input logic [15:0] lz, input logic [15:0] px,
                                          input logic [15:0] py);
    logic [15:0] a, b, c;
    a = lx + px * 16'd7;
    b = ly + py * 16'd13;
    c = lz ^ (px + py * 16'd4);
    return {a[7:0], b[7:0], c[7:0]};
  endfunction

  always @(posedge clk) bus.color <= ball_fn(bus.x_loc, bus.y_loc, bus.z_loc,
                                             bus.pixel_x, bus.pixel_y);

  // out_ready driver: 0 = low, 1 = high, 2 = random.
  int ready_mode = 1;
  always @(posedge clk) begin
    #1;
    if (ready_mode == 0)      bus.out_ready = 1'b0;
    else if (ready_mode == 1) bus.out_ready = 1'b1;
    else                      bus.out_ready = 1'($urandom_range(0, 1));
  end

  // Scoreboard
  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [23:0] c;
    logic        last;
  } exp_t;
  exp_t sb_q[$];

  logic [15:0] exp_lx, exp_ly, exp_lz;
  bit          loc_chk = 0;
  int          beats_seen = 0;
  int          done_seen = 0;

  task automatic push_frame(input logic [15:0] lx, input logic [15:0] ly, input logic [15:0] lz);
    exp_t e;
    for (int yy = 0; yy < V; yy++) begin
      for (int xx = 0; xx < H; xx++) begin
        e.x    = 16'(xx);
        e.y    = 16'(yy);
        e.c    = ball_fn(lx, ly, lz, 16'(xx), 16'(yy));
        e.last = (xx == H - 1) && (yy == V - 1);
        sb_q.push_back(e);
      end
    end
  endtask

  // Monitor
  bit          prev_stall = 0;
  logic [56:0] prev_beat;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall)
        check("stall_stable", {bus.out_valid, bus.out_x, bus.out_y, bus.out_color, bus.out_last},
              {1'b1, prev_beat});
      prev_stall = 0;
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got (%0d,%0d), expected none", bus.out_x, bus.out_y);
          end else begin
            e = sb_q.pop_front();
            check("beat", {bus.out_x, bus.out_y, bus.out_color, bus.out_last},
                  {e.x, e.y, e.c, e.last});
          end
          beats_seen++;
        end else begin
          prev_stall = 1;
          prev_beat  = {bus.out_x, bus.out_y, bus.out_color, bus.out_last};
        end
      end
      if (bus.frame_done) done_seen++;
      if (loc_chk && bus.busy)
        check("loc_hold", {bus.x_loc, bus.y_loc, bus.z_loc}, {exp_lx, exp_ly, exp_lz});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pos(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    int n = 0;
    bus.pos_valid = 1'b1;
    bus.pos_x = x;
    bus.pos_y = y;
    bus.pos_z = z;
    while (!bus.pos_ready && n < 200) begin
      tick();
      n++;
    end
    if (!bus.pos_ready) fail_now("pos_accept");
    tick();
    bus.pos_valid = 1'b0;
  endtask

  task automatic start_frame(input logic [15:0] lx, input logic [15:0] ly, input logic [15:0] lz);
    push_frame(lx, ly, lz);
    exp_lx = lx;
    exp_ly = ly;
    exp_lz = lz;
    loc_chk = 1;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!bus.frame_done && n < budget) begin
      tick();
      n++;
    end
    if (!bus.frame_done) fail_now("frame_done");
    tick();
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    check("busy_after", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, n, b0;
    logic [15:0] rx, ry, rz;
    bus.pos_valid   = 1'b0;
    bus.pos_x       = '0;
    bus.pos_y       = '0;
    bus.pos_z       = '0;
    bus.frame_start = 1'b0;

    // 1. Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check("rst_pos_ready", 64'(bus.pos_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_pixel", {bus.pixel_x, bus.pixel_y}, 64'd0);
    check("rst_overrun", 64'(bus.overrun), 64'd0);
    check("rst_loc", {bus.x_loc, bus.y_loc, bus.z_loc}, 64'd0);
    check("rst_out", {bus.out_x, bus.out_y, bus.out_color, bus.out_last}, 64'd0);

    // 2. Basic frame with latency check
    send_pos(16'd10, 16'd20, 16'd5);
    d0 = done_seen;
    start_frame(16'd10, 16'd20, 16'd5);
    check("first_issue", {bus.pixel_x, bus.pixel_y, 15'd0, bus.busy}, 64'd1);
    check("lat_t1", 64'(bus.out_valid), 64'd0);
    tick();
    check("lat_t2", 64'(bus.out_valid), 64'd0);
    tick();
    check("lat_t3", 64'(bus.out_valid), 64'd1);
    wait_done(200);
    repeat (3) tick();
    check("done_once", 64'(done_seen - d0), 64'd1);

    // 3. Backpressure from frame start
    ready_mode = 0;
    tick();
    start_frame(16'd10, 16'd20, 16'd5);
    repeat (20) tick();
    check("bp_pixel_hold", {bus.pixel_x, bus.pixel_y}, {16'd3, 16'd0});
    check("bp_head", {bus.out_valid, bus.out_x, bus.out_y}, {1'b1, 16'd0, 16'd0});
    ready_mode = 1;
    wait_done(200);

    // 4. Position offered during SCAN is held off until IDLE
    start_frame(16'd10, 16'd20, 16'd5);
    tick();
    bus.pos_valid = 1'b1;
    bus.pos_x = 16'd7;
    bus.pos_y = 16'd7;
    bus.pos_z = 16'd7;
    n = 0;
    while (!bus.frame_done && n < 200) begin
      check("pos_ready_busy", 64'(bus.pos_ready), 64'd0);
      tick();
      n++;
    end
    if (!bus.frame_done) fail_now("frame_done_t4");
    check("pos_ready_done", 64'(bus.pos_ready), 64'd0);
    check("loc_in_done", 64'(bus.x_loc), 64'd10);
    tick();
    check("pos_ready_idle", 64'(bus.pos_ready), 64'd1);
    tick();
    bus.pos_valid = 1'b0;
    check("loc_new", {bus.x_loc, bus.y_loc, bus.z_loc}, {16'd7, 16'd7, 16'd7});
    start_frame(16'd7, 16'd7, 16'd7);
    wait_done(200);

    // 5. frame_start while busy is ignored and sets overrun
    ready_mode = 2;
    rx = 16'($urandom);
    ry = 16'($urandom);
    rz = 16'($urandom);
    send_pos(rx, ry, rz);
    start_frame(rx, ry, rz);
    repeat (3) tick();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    check("overrun_set", 64'(bus.overrun), 64'd1);
    wait_done(400);
    repeat (10) tick();
    check("overrun_sticky", {bus.overrun, bus.busy}, {1'b1, 1'b0});

    // Random frames with random backpressure
    for (int f = 0; f < 3; f++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      rz = 16'($urandom);
      send_pos(rx, ry, rz);
      start_frame(rx, ry, rz);
      wait_done(400);
    end

    // 6. Reset mid-frame
    ready_mode = 1;
    rx = 16'($urandom);
    ry = 16'($urandom);
    rz = 16'($urandom);
    send_pos(rx, ry, rz);
    b0 = beats_seen;
    d0 = done_seen;
    start_frame(rx, ry, rz);
    n = 0;
    while (beats_seen < b0 + 5 && n < 100) begin
      tick();
      n++;
    end
    if (beats_seen < b0 + 5) fail_now("five_beats");
    rst = 1'b1;
    loc_chk = 0;
    tick();
    rst = 1'b0;
    sb_q.delete();
    check("abort_state", {bus.out_valid, bus.busy, bus.frame_done, bus.overrun}, 64'd0);
    check("abort_pixel", {bus.pixel_x, bus.pixel_y}, 64'd0);
    repeat (4) tick();
    check("abort_no_done", 64'(done_seen - d0), 64'd0);
    rx = 16'($urandom);
    ry = 16'($urandom);
    rz = 16'($urandom);
    send_pos(rx, ry, rz);
    b0 = beats_seen;
    start_frame(rx, ry, rz);
    wait_done(200);
    check("post_rst_beats", 64'(beats_seen - b0), 64'd12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
